sys_bus_arbiter: RTL and testbench
==================================

SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 SHALL have parameter DM_BASE_HI, default 16'h0000, meaning the upper address half selecting data memory.
REQ-002 SHALL have parameter IO_BASE_HI, default 16'h7F00, meaning the upper address half selecting the IO unit.
REQ-003 SHALL have ports: clk  in  1  system clock, single clock domain; reset is synchronous and active-low.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 m0_req/m1_req  in  1 each  master request (m0 = CPU data port, m1 = DMA engine).
REQ-006 m0_addr/m1_addr  in  32  byte address; m0_din/m1_din  in  32  write data.
REQ-007 m0_BE/m1_BE  in  4  byte enables; m0_wr/m1_wr  in  1  1 = write, 0 = read.
REQ-008 m0_ack/m1_ack  out  1  one-cycle completion pulse; m0_rdata/m1_rdata  out  32  read data, valid while ack = 1.
REQ-009 m0_err/m1_err  out  1  unmapped-address flag, valid while ack = 1.
REQ-010 bus_addr  out  32; bus_din  out  32; bus_BE  out  4; bus_wr  out  1  bridge-side drive.
REQ-011 bus_dout  in  32  bridge read data, combinational from bus_addr.

Function
REQ-012 SHALL implement FSM states IDLE, ACC and RESP, plus a 1-bit round-robin pointer rr (0 = m0 preferred).
REQ-013 IDLE: if any request is pending, SHALL select a winner, latch its addr/din/BE/wr into bus registers and go to ACC; otherwise stay in IDLE.
REQ-014 Arbitration: a single requester SHALL win; with both requesting, the master indicated by rr SHALL win; after each grant rr SHALL point to the other master.
REQ-015 ACC (exactly 1 cycle): bus_addr/bus_din/bus_BE SHALL hold the latched values; bus_wr SHALL equal the latched wr; bus_dout SHALL be captured into the response register; next state is RESP.
REQ-016 bus_wr SHALL be 1 only in ACC, so each write is a single-cycle pulse; outside ACC, bus_wr = 0 and bus_addr/bus_din/bus_BE SHALL hold their last values.
REQ-017 RESP: the granted master's ack SHALL be 1 for exactly one cycle, with its rdata = captured bus_dout (reads) or 32'h0 (writes); the other master's ack SHALL stay 0.
REQ-018 err SHALL be 1 in RESP when addr[31:16] matches neither DM_BASE_HI nor IO_BASE_HI; for such accesses bus_wr SHALL remain 0 in ACC and rdata SHALL be 32'hFFFFFFFF.
REQ-019 RESP exit: if the non-acked master is requesting, SHALL latch it and go to ACC (rr updated); otherwise go to IDLE; the acked master's req is ignored during RESP.
REQ-020 Latency: request seen in IDLE at cycle N -> ACC at N+1 -> ack at N+2; back-to-back alternating transfers SHALL complete one every 2 cycles.
REQ-021 Masters SHALL hold req, addr, din, BE and wr stable until ack; the arbiter samples request fields only on the transition into ACC.
REQ-022 A req deasserted before grant SHALL be dropped without any bus activity.
REQ-023 rdata SHALL hold its value between acks; only ack qualifies validity.

Reset
REQ-024 When rst_n = 0 at a clk edge: state = IDLE, rr = 0, all ack/err = 0, bus_wr = 0, bus_addr/bus_din = 0, bus_BE = 0, rdata = 0.
REQ-025 Reset during ACC or RESP SHALL abort the transfer: no ack is issued and bus_wr is 0 from the next cycle; an aborted write may or may not have landed.

Verification
REQ-026 m0 write addr 0x00000010, din 0xDEADBEEF, BE 4'hF -> bus_wr = 1 for exactly 1 cycle at N+1; m0_ack at N+2; m0 read of 0x10 -> m0_rdata = 0xDEADBEEF.
REQ-027 m0 and m1 both request from reset -> m0 granted first, m1 acked 2 cycles after m0; m0 re-requesting immediately -> m0 acked 2 cycles after m1 (alternation).
REQ-028 m1 read of 0x3000_0000 (unmapped) -> m1_err = 1 with m1_ack, m1_rdata = 0xFFFFFFFF, bus_wr never 1.
REQ-029 m1 read of IO address 0x7F00_0004 -> bus_addr = 0x7F000004 in ACC, m1_rdata = bus_dout value captured in ACC.
REQ-030 rst_n = 0 asserted in ACC of an m0 write -> no m0_ack, bus_wr = 0 next cycle, rr = 0; after release, m0 and m1 both requesting -> m0 wins.
REQ-031 Single-master stream: m0 held requesting with a new transfer each ack -> one ack every 3 cycles (IDLE, ACC, RESP), no ack ever asserted to m1.

Source files
------------

// File: rtl/sys_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bus_arbiter_if
//  Purpose  : Two-master request/ack bundle plus bridge-side bus for the
//             sys_bus_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface sys_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_din;
    logic [3:0]  m0_BE;
    logic        m0_wr;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_din;
    logic [3:0]  m1_BE;
    logic        m1_wr;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] bus_addr;
    logic [31:0] bus_din;
    logic [3:0]  bus_BE;
    logic        bus_wr;
    logic [31:0] bus_dout;

    // Environment side: both masters and the bridge read-data return
    modport master (
        output m0_req, m0_addr, m0_din, m0_BE, m0_wr,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_din, m1_BE, m1_wr,
        input  m1_ack, m1_rdata, m1_err,
        input  bus_addr, bus_din, bus_BE, bus_wr,
        output bus_dout
    );

    modport slave (
        input  m0_req, m0_addr, m0_din, m0_BE, m0_wr,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_din, m1_BE, m1_wr,
        output m1_ack, m1_rdata, m1_err,
        output bus_addr, bus_din, bus_BE, bus_wr,
        input  bus_dout
    );
endinterface
`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bus_arbiter
//  Purpose  : Round-robin arbiter granting a CPU data port (m0) and a DMA
//             engine (m1) single-cycle access to a shared bridge bus.
//  Revision : 1.0  initial release
// ============================================================================
module sys_bus_arbiter #(
    parameter logic [15:0] DM_BASE_HI = 16'h0000,
    parameter logic [15:0] IO_BASE_HI = 16'h7F00
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sys_bus_arbiter_if.slave  arb_bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_rr;
    logic        r_gnt;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [3:0]  r_be;
    logic        r_wr;
    logic        r_err;

    logic        r_m0_ack;
    logic        r_m0_err;
    logic [31:0] r_m0_rdata;
    logic        r_m1_ack;
    logic        r_m1_err;
    logic [31:0] r_m1_rdata;

    logic        w_win;
    logic        w_other_req;
    logic        w_grant;
    logic        w_sel;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_din;
    logic [3:0]  w_sel_be;
    logic        w_sel_wr;
    logic        w_sel_unmapped;
    logic [31:0] w_resp;

    // With both masters requesting, rr names the winner; otherwise the lone requester wins
    assign w_win       = (arb_bus.m0_req && arb_bus.m1_req) ? r_rr : arb_bus.m1_req;
    assign w_other_req = r_gnt ? arb_bus.m0_req : arb_bus.m1_req;

    always_comb begin
        w_grant = 1'b0;
        w_sel   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_grant = arb_bus.m0_req || arb_bus.m1_req;
                w_sel   = w_win;
            end
            c_RESP: begin
                w_grant = w_other_req;
                w_sel   = ~r_gnt;
            end
            default: begin
                w_grant = 1'b0;
                w_sel   = 1'b0;
            end
        endcase
    end

    assign w_sel_addr     = w_sel ? arb_bus.m1_addr : arb_bus.m0_addr;
    assign w_sel_din      = w_sel ? arb_bus.m1_din  : arb_bus.m0_din;
    assign w_sel_be       = w_sel ? arb_bus.m1_BE   : arb_bus.m0_BE;
    assign w_sel_wr       = w_sel ? arb_bus.m1_wr   : arb_bus.m0_wr;
    assign w_sel_unmapped = (w_sel_addr[31:16] != DM_BASE_HI) &&
                            (w_sel_addr[31:16] != IO_BASE_HI);

    assign w_resp = r_wr  ? 32'h0000_0000 :
                    r_err ? 32'hFFFF_FFFF : arb_bus.bus_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_rr       <= 1'b0;
            r_gnt      <= 1'b0;
            r_addr     <= 32'h0;
            r_din      <= 32'h0;
            r_be       <= 4'h0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= 32'h0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= 32'h0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m1_err <= 1'b0;

            case (r_state)
                c_IDLE: r_state <= w_grant ? c_ACC : c_IDLE;
                c_ACC: begin
                    r_state <= c_RESP;
                    // Response registers are loaded here so the ack appears in RESP
                    if (r_gnt) begin
                        r_m1_ack   <= 1'b1;
                        r_m1_err   <= r_err;
                        r_m1_rdata <= w_resp;
                    end else begin
                        r_m0_ack   <= 1'b1;
                        r_m0_err   <= r_err;
                        r_m0_rdata <= w_resp;
                    end
                end
                c_RESP:  r_state <= w_grant ? c_ACC : c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            if (w_grant) begin
                r_gnt  <= w_sel;
                r_rr   <= ~w_sel;
                r_addr <= w_sel_addr;
                r_din  <= w_sel_din;
                r_be   <= w_sel_be;
                r_wr   <= w_sel_wr;
                r_err  <= w_sel_unmapped;
            end
        end
    end

    // Unmapped writes never reach the bridge
    assign arb_bus.bus_wr   = (r_state == c_ACC) && r_wr && !r_err;
    assign arb_bus.bus_addr = r_addr;
    assign arb_bus.bus_din  = r_din;
    assign arb_bus.bus_BE   = r_be;

    assign arb_bus.m0_ack   = r_m0_ack;
    assign arb_bus.m0_err   = r_m0_err;
    assign arb_bus.m0_rdata = r_m0_rdata;
    assign arb_bus.m1_ack   = r_m1_ack;
    assign arb_bus.m1_err   = r_m1_err;
    assign arb_bus.m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_bus_arbiter
//  Purpose  : Randomised scoreboard bench for sys_bus_arbiter with a
//             transaction-level memory and arbitration model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sys_bus_arbiter;

    localparam logic [15:0] DM_HI = 16'h0000;
    localparam logic [15:0] IO_HI = 16'h7F00;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        wr;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        wr;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sys_bus_arbiter_if bif();

    sys_bus_arbiter #(
        .DM_BASE_HI (DM_HI),
        .IO_BASE_HI (IO_HI)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_bus (bif.slave)
    );

    exp_t        q0[$];
    exp_t        q1[$];
    acc_t        acc_q[$];
    txn_t        dir0[$];
    txn_t        dir1[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem [0:127];
    logic [6:0]  midx;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          rr_m;

    always @(posedge clk) cyc <= cyc + 1;

    // Bridge: DM and IO windows kept apart by address bit 30
    assign midx         = {bif.bus_addr[30], bif.bus_addr[7:2]};
    assign bif.bus_dout = mem[midx];
    always @(posedge clk) begin
        if (bif.bus_wr) begin
            for (int b = 0; b < 4; b++)
                if (bif.bus_BE[b]) mem[midx][8*b +: 8] <= bif.bus_din[8*b +: 8];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit unmapped(input logic [31:0] a);
        return (a[31:16] != DM_HI) && (a[31:16] != IO_HI);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [15:0] hi;
        int r;
        r = $urandom_range(0, 4);
        case (r)
            0, 1:    hi = DM_HI;
            2, 3:    hi = IO_HI;
            default: begin
                case ($urandom_range(0, 3))
                    0:       hi = 16'h3000;
                    1:       hi = 16'h1234;
                    2:       hi = 16'h7F01;
                    default: hi = 16'hFFFF;
                endcase
            end
        endcase
        // Word 63 of each window is reserved for the reset-abort write
        t.addr = {hi, 8'h00, 6'($urandom_range(0, 62)), 2'b00};
        t.din  = $urandom;
        t.be   = 4'($urandom_range(0, 15));
        t.wr   = 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic drive(input int m, input txn_t t);
        if (m == 0) begin
            bif.m0_addr = t.addr; bif.m0_din = t.din; bif.m0_BE = t.be; bif.m0_wr = t.wr;
            bif.m0_req  = 1'b1;
        end else begin
            bif.m1_addr = t.addr; bif.m1_din = t.din; bif.m1_BE = t.be; bif.m1_wr = t.wr;
            bif.m1_req  = 1'b1;
        end
    endtask

    // Present a new transfer and record what it must produce, in service order
    task automatic issue(input int m, input int ack_c);
        txn_t        t;
        exp_t        e;
        acc_t        a;
        logic [31:0] key;
        logic [31:0] cur;
        if (m == 0 && dir0.size() > 0)      t = dir0.pop_front();
        else if (m == 1 && dir1.size() > 0) t = dir1.pop_front();
        else                                t = rand_txn();
        drive(m, t);
        key   = {t.addr[31:2], 2'b00};
        cur   = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        e.err = unmapped(t.addr);
        e.cyc = ack_c;
        if (t.wr) begin
            e.rdata = 32'h0;
            if (!e.err) begin
                for (int b = 0; b < 4; b++)
                    if (t.be[b]) cur[8*b +: 8] = t.din[8*b +: 8];
                ref_mem[key] = cur;
            end
        end else begin
            e.rdata = e.err ? 32'hFFFF_FFFF : cur;
        end
        a.cyc  = ack_c - 1;
        a.addr = t.addr;
        a.din  = t.din;
        a.be   = t.be;
        a.wr   = t.wr && !e.err;
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        acc_q.push_back(a);
    endtask

    // n transfers per enabled master, each master re-requesting at its own ack
    task automatic run_stream(input bit en0, input bit en1, input int n, input bit drop1);
        int  c0, step, slots, limit, w;
        int  rem[2];
        bit  both;
        acc_t a;
        c0     = cyc;
        both   = en0 && en1;
        w      = both ? int'(rr_m) : (en0 ? 0 : 1);
        step   = both ? 2 : 3;
        slots  = both ? 2 * n : n;
        limit  = c0 + 2 + step * (slots - 1) + 3;
        rem[0] = en0 ? n : 0;
        rem[1] = en1 ? n : 0;
        issue(w, c0 + 2);
        rem[w]--;
        if (both) begin
            issue(1 - w, c0 + 4);
            rem[1 - w]--;
        end
        rr_m = both ? rr_m : (w == 0);
        while (cyc < limit) begin
            @(negedge clk);
            if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                a = acc_q.pop_front();
                check("acc_bus_addr", bif.bus_addr, a.addr);
                check("acc_bus_din",  bif.bus_din,  a.din);
                check("acc_bus_BE",   32'(bif.bus_BE), 32'(a.be));
                check("acc_bus_wr",   32'(bif.bus_wr), 32'(a.wr));
            end else begin
                check("bus_wr_outside_acc", 32'(bif.bus_wr), 0);
            end
            if (drop1 && cyc == c0 + 1) begin
                bif.m1_addr = 32'h0000_0040; bif.m1_din = 32'hBAD0_BAD0;
                bif.m1_BE   = 4'hF;          bif.m1_wr  = 1'b1;
                bif.m1_req  = 1'b1;
            end
            if (drop1 && cyc == c0 + 2) bif.m1_req = 1'b0;
            if (bif.m0_ack) begin
                if (rem[0] > 0) begin issue(0, cyc + step + (both ? 2 : 0)); rem[0]--; end
                else bif.m0_req = 1'b0;
            end
            if (bif.m1_ack) begin
                if (rem[1] > 0) begin issue(1, cyc + step + (both ? 2 : 0)); rem[1]--; end
                else bif.m1_req = 1'b0;
            end
        end
        check("stream_drained", 32'(q0.size() + q1.size() + acc_q.size()), 0);
        q0.delete(); q1.delete(); acc_q.delete();
        bif.m0_req = 1'b0;
        bif.m1_req = 1'b0;
    endtask

    task automatic reset_abort();
        bif.m0_addr = 32'h0000_00FC; bif.m0_din = 32'h5555_AAAA;
        bif.m0_BE   = 4'hF;          bif.m0_wr  = 1'b1;
        bif.m0_req  = 1'b1;
        @(negedge clk);
        check("abort_acc_wr", 32'(bif.bus_wr), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_ack",   32'(bif.m0_ack), 0);
        check("abort_bus_wr",   32'(bif.bus_wr), 0);
        check("abort_rdata",    bif.m0_rdata, 32'h0);
        check("abort_bus_addr", bif.bus_addr, 32'h0);
        bif.m0_req = 1'b0;
        rr_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_no_ack", 32'(bif.m0_ack), 0);
    endtask

    // Scoreboard monitor: every ack must match the oldest expectation for that master
    always @(negedge clk) begin
        exp_t e;
        if (bif.m0_ack) begin
            check("single_ack", 32'(bif.m1_ack), 0);
            check("m0_ack_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("m0_rdata", bif.m0_rdata, e.rdata);
                check("m0_err", 32'(bif.m0_err), 32'(e.err));
                check("m0_ack_cycle", cyc, e.cyc);
            end
        end
        if (bif.m1_ack) begin
            check("m1_ack_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("m1_rdata", bif.m1_rdata, e.rdata);
                check("m1_err", 32'(bif.m1_err), 32'(e.err));
                check("m1_ack_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, n;
        bit drop;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        bif.m0_req = 1'b0; bif.m0_addr = 32'h0; bif.m0_din = 32'h0; bif.m0_BE = 4'h0; bif.m0_wr = 1'b0;
        bif.m1_req = 1'b0; bif.m1_addr = 32'h0; bif.m1_din = 32'h0; bif.m1_BE = 4'h0; bif.m1_wr = 1'b0;
        rr_m  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m0_ack",   32'(bif.m0_ack), 0);
        check("rst_m1_ack",   32'(bif.m1_ack), 0);
        check("rst_m0_err",   32'(bif.m0_err), 0);
        check("rst_m1_err",   32'(bif.m1_err), 0);
        check("rst_bus_wr",   32'(bif.bus_wr), 0);
        check("rst_bus_addr", bif.bus_addr, 32'h0);
        check("rst_bus_din",  bif.bus_din, 32'h0);
        check("rst_bus_BE",   32'(bif.bus_BE), 0);
        check("rst_m0_rdata", bif.m0_rdata, 32'h0);
        check("rst_m1_rdata", bif.m1_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both from reset: m0 first, then strict alternation
        run_stream(1'b1, 1'b1, 2, 1'b0);

        dir0.push_back('{addr: 32'h0000_0010, din: 32'hDEAD_BEEF, be: 4'hF, wr: 1'b1});
        dir0.push_back('{addr: 32'h0000_0010, din: 32'h0000_0000, be: 4'hF, wr: 1'b0});
        run_stream(1'b1, 1'b0, 2, 1'b0);

        dir1.push_back('{addr: 32'h3000_0000, din: 32'h1234_5678, be: 4'hF, wr: 1'b0});
        run_stream(1'b0, 1'b1, 1, 1'b0);

        dir1.push_back('{addr: 32'h7F00_0004, din: 32'hA5A5_1234, be: 4'hF, wr: 1'b1});
        dir1.push_back('{addr: 32'h7F00_0004, din: 32'h0000_0000, be: 4'hF, wr: 1'b0});
        run_stream(1'b0, 1'b1, 2, 1'b0);

        reset_abort();
        run_stream(1'b1, 1'b1, 1, 1'b0);

        run_stream(1'b1, 1'b0, 5, 1'b0);
        run_stream(1'b1, 1'b0, 1, 1'b1);

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            drop = (mode == 0) && (n == 1) && ($urandom_range(0, 1) == 1);
            run_stream(mode != 1, mode != 0, n, drop);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
